branch_predict_ctrl: RTL

//   Fetch-side branch scheduler for the pipelined core. Holds a bimodal table
//   of 2-bit saturating counters that predicts fetched branches. Compares each
//   EX-stage prediction with the resolved PCSrc from the branch compare logic.
//   On a mismatch it redirects the PC, flushes IF/ID and ID/EX, and runs a
//   one-cycle recovery. Keeps saturating branch and mispredict statistics.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/bht_table.sv | 39 +++
 rtl/branch_predict_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//   - bht_cnt_e   : 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   - bp_state_e  : scheduler FSM states (IDLE/RECOVER)
//   - BHT_RST_VAL : value every table entry takes on reset (weakly not-taken)
//   - sat_step()  : one saturating step of a counter toward the resolved outcome
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bp_state_e;

  localparam logic [1:0] BHT_RST_VAL = WNT;
  localparam logic [1:0] BHT_MAX     = ST;
  localparam logic [1:0] BHT_MIN     = SNT;

  // Move one step toward the outcome, clamping at the strong states.
  function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != BHT_MAX) nxt = cur + 2'd1;
    end else begin
      if (cur != BHT_MIN) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Bimodal history table: 2**IDX_W entries of 2-bit saturating counters.
// Ports:
//   clk, reset        : clock, async active-high reset (all entries -> WNT)
//   rd_idx / rd_taken : combinational read, returns the entry's MSB
//   wr_en, wr_idx,
//   wr_taken          : synchronous saturating update of one entry
// A read and a write to the same index in one cycle return the old value;
// the update lands on the clock edge and there is no bypass.
module bht_table
  import branch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0][1:0] tbl_q, tbl_d;

  always_comb begin
    tbl_d = tbl_q;
    if (wr_en) tbl_d[wr_idx] = sat_step(tbl_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tbl_q <= {ENTRIES{BHT_RST_VAL}};
    else       tbl_q <= tbl_d;
  end

  assign rd_taken = tbl_q[rd_idx][1];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch scheduler. Predicts fetched branches from a bimodal
// table, compares the EX-stage prediction against the resolved outcome,
// and on a mismatch redirects the PC, flushes IF/ID and ID/EX, then spends
// one cycle in RECOVER while the flushed bubble passes through EX.
// Ports:
//   clk, reset          : clock, async active-high reset
//   if_pc / pred_taken  : fetch PC and its combinational prediction
//   ex_valid, ex_branch,
//   ex_pc, ex_pred_taken,
//   ex_pcsrc            : EX-stage branch info and resolved outcome
//   redirect, redirect_taken, flush : same-cycle mispredict recovery controls
//   recovering          : registered, high during the RECOVER cycle
//   br_count, mispred_count : saturating statistics
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_pcsrc,
  output logic             redirect,
  output logic             redirect_taken,
  output logic             flush,
  output logic             recovering,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  bp_state_e        state_q, state_d;
  logic             recovering_q, recovering_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mispred_count_q, mispred_count_d;
  logic             res, mis;

  // Only word-aligned PC bits above the byte offset select a table entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  // EX is ignored while recovering: that slot holds the flushed bubble.
  assign res = ex_valid & ex_branch & (state_q == IDLE);
  assign mis = res & (ex_pcsrc != ex_pred_taken);

  assign redirect       = mis;
  assign flush          = mis;
  assign redirect_taken = ex_pcsrc;

  bht_table #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_taken (pred_taken),
    .wr_en    (res),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (ex_pcsrc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mis) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    recovering_d = (state_d == RECOVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      recovering_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      recovering_q <= recovering_d;
    end
  end

  assign recovering = recovering_q;

  // Statistics hold at all-ones rather than wrapping.
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (res && (br_count_q != '1))      br_count_d      = br_count_q + CNT_W'(1);
    if (mis && (mispred_count_q != '1)) mispred_count_d = mispred_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule
